gps_rom_search_ctrl: RTL and testbench

- Sequencer and arbiter for a shared sorted lookup ROM, such as the COS or ASIN table used by the GPS distance datapath.
- Serves two requesters in round-robin order. For each request it scans the ROM and finds the bracketing entry pair (key_lo ≤ query < key_hi) for that requester's query.
- Returns both entries and their index so the datapath can do linear interpolation.
- Sits between the distance-calculation FSM/datapath and the ROM address/data ports.

---
 rtl/gps_pkg.sv | 27 ++
 rtl/gps_rom_search_ctrl_if.sv | 34 +++
 rtl/gps_rr_arb2.sv | 24 ++
 rtl/gps_rom_search_ctrl.sv | 146 ++++++++++++++
 tb/tb_gps_rom_search_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/gps_pkg.sv
// Shared types for the GPS ROM search controller: FSM states, default widths
// and the {key,val} ROM word layout.
package gps_pkg;

    localparam int GPS_AW = 7;
    localparam int GPS_KW = 48;
    localparam int GPS_VW = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [GPS_KW-1:0] key;
        logic [GPS_VW-1:0] val;
    } rom_word_t;

    function automatic rom_word_t split_rom_word(input logic [GPS_KW+GPS_VW-1:0] word);
        rom_word_t w;
        w.key = word[GPS_KW+GPS_VW-1:GPS_VW];
        w.val = word[GPS_VW-1:0];
        return w;
    endfunction

endpackage

// File: rtl/gps_rom_search_ctrl_if.sv
// Requester and ROM-side signals of the ROM search controller.
interface gps_rom_search_ctrl_if #(
    parameter int AW = 7,
    parameter int KW = 48,
    parameter int VW = 48
);
    logic [1:0]       req;
    logic [KW-1:0]    query0;
    logic [KW-1:0]    query1;
    logic [AW-1:0]    rom_addr;
    logic [KW+VW-1:0] rom_data;
    logic             busy;
    logic [1:0]       done;
    logic             rsp_id;
    logic [KW-1:0]    key_lo;
    logic [VW-1:0]    val_lo;
    logic [KW-1:0]    key_hi;
    logic [VW-1:0]    val_hi;
    logic [AW-1:0]    idx_lo;
    logic             oor_lo;
    logic             oor_hi;

    modport master (
        output req, query0, query1, rom_data,
        input  rom_addr, busy, done, rsp_id, key_lo, val_lo, key_hi, val_hi,
               idx_lo, oor_lo, oor_hi
    );

    modport slave (
        input  req, query0, query1, rom_data,
        output rom_addr, busy, done, rsp_id, key_lo, val_lo, key_hi, val_hi,
               idx_lo, oor_lo, oor_hi
    );
endinterface

// File: rtl/gps_rr_arb2.sv
// Two-requester round-robin arbiter; r_last remembers the previous winner and
// is only updated when the grant is actually taken (i_en).
module gps_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic       o_gnt_vld,
    output logic       o_gnt_id
);
    logic r_last;

    assign o_gnt_vld = |i_req;
    assign o_gnt_id  = (&i_req) ? ~r_last : i_req[1];

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (i_en && o_gnt_vld) begin
            r_last <= o_gnt_id;
        end
    end
endmodule

// File: rtl/gps_rom_search_ctrl.sv
// Linear-scan bracket search over a sorted ROM shared by two requesters.
//   state | meaning
//   IDLE  | wait for a request, arbitrate, latch query, prefetch address 1
//   SCAN  | consume one ROM entry per cycle until key > query or last entry
//   DONE  | one-cycle done pulse to the owner; results already registered
module gps_rom_search_ctrl
    import gps_pkg::*;
#(
    parameter int AW    = GPS_AW,
    parameter int KW    = GPS_KW,
    parameter int VW    = GPS_VW,
    parameter int DEPTH = 128
) (
    input logic                  clk,
    input logic                  reset_n,
    gps_rom_search_ctrl_if.slave bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          r_state;
    state_t          w_next;
    logic            w_gnt_vld;
    logic            w_gnt_id;
    logic            w_grant;
    rom_word_t       w_word;
    logic            w_last;
    logic            w_above;
    logic            w_hit;

    logic [KW-1:0]   r_query;
    logic            r_id;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_rom_addr;
    logic [KW-1:0]   r_prev_key;
    logic [VW-1:0]   r_prev_val;
    logic            r_oor_lo_pend;
    logic [KW-1:0]   r_key_lo;
    logic [VW-1:0]   r_val_lo;
    logic [KW-1:0]   r_key_hi;
    logic [VW-1:0]   r_val_hi;
    logic [AW-1:0]   r_idx_lo;
    logic            r_oor_lo;
    logic            r_oor_hi;
    logic            r_rsp_id;

    assign w_grant = (r_state == IDLE) && w_gnt_vld;

    gps_rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_en      (w_grant),
        .i_req     (bus.req),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    // r_idx is the index of the entry arriving on rom_data this cycle.
    assign w_word  = split_rom_word(bus.rom_data);
    assign w_last  = (r_idx == LAST_ADDR);
    assign w_above = (w_word.key > r_query);
    assign w_hit   = (r_idx != '0) && (w_above || w_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_next = SCAN;
            SCAN:    if (w_hit)     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state == SCAN);
        bus.done = {(r_state == DONE) &&  r_rsp_id,
                    (r_state == DONE) && !r_rsp_id};
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.rsp_id   = r_rsp_id;
    assign bus.key_lo   = r_key_lo;
    assign bus.val_lo   = r_val_lo;
    assign bus.key_hi   = r_key_hi;
    assign bus.val_hi   = r_val_hi;
    assign bus.idx_lo   = r_idx_lo;
    assign bus.oor_lo   = r_oor_lo;
    assign bus.oor_hi   = r_oor_hi;

    // rom_addr runs one entry ahead of r_idx to cover the ROM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_query       <= '0;
            r_id          <= 1'b0;
            r_idx         <= '0;
            r_rom_addr    <= '0;
            r_prev_key    <= '0;
            r_prev_val    <= '0;
            r_oor_lo_pend <= 1'b0;
            r_key_lo      <= '0;
            r_val_lo      <= '0;
            r_key_hi      <= '0;
            r_val_hi      <= '0;
            r_idx_lo      <= '0;
            r_oor_lo      <= 1'b0;
            r_oor_hi      <= 1'b0;
            r_rsp_id      <= 1'b0;
        end else begin
            if (w_grant) begin
                r_query    <= w_gnt_id ? bus.query1 : bus.query0;
                r_id       <= w_gnt_id;
                r_idx      <= '0;
                r_rom_addr <= AW'(1);
            end else if (r_state == SCAN) begin
                if (w_hit) begin
                    r_key_lo   <= r_prev_key;
                    r_val_lo   <= r_prev_val;
                    r_key_hi   <= w_word.key;
                    r_val_hi   <= w_word.val;
                    r_idx_lo   <= r_idx - AW'(1);
                    r_oor_lo   <= r_oor_lo_pend;
                    r_oor_hi   <= w_last && !w_above;
                    r_rsp_id   <= r_id;
                    r_rom_addr <= '0;
                end else begin
                    if (r_idx == '0) begin
                        r_oor_lo_pend <= (r_query < w_word.key);
                    end
                    r_prev_key <= w_word.key;
                    r_prev_val <= w_word.val;
                    r_idx      <= r_idx + AW'(1);
                    if (r_rom_addr != LAST_ADDR) begin
                        r_rom_addr <= r_rom_addr + AW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gps_rom_search_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed brackets, a negedge monitor
// pops and compares on every done pulse. ROM: DEPTH=8, key_k=10(k+1), val_k=1000+k.
module tb_gps_rom_search_ctrl;
    import gps_pkg::*;

    localparam int AW    = 7;
    localparam int KW    = 48;
    localparam int VW    = 48;
    localparam int DEPTH = 8;

    typedef struct {
        int     id;
        longint klo;
        longint khi;
        longint vlo;
        longint vhi;
        int     idx;
        int     olo;
        int     ohi;
        int     lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   t_start = 0;
    bit   prev_busy = 1'b0;
    int   rom_max = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gps_rom_search_ctrl_if #(.AW(AW), .KW(KW), .VW(VW)) bus ();

    gps_rom_search_ctrl #(.AW(AW), .KW(KW), .VW(VW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [KW+VW-1:0] rom_word(input logic [AW-1:0] a);
        logic [KW-1:0] k;
        logic [VW-1:0] v;
        if (int'(a) >= DEPTH) return '0;
        k = KW'(10 * (int'(a) + 1));
        v = VW'(1000 + int'(a));
        return {k, v};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input longint klo, input longint khi,
                        input longint vlo, input longint vhi, input int idx,
                        input int olo, input int ohi, input int lat);
        exp_t e;
        e.id = id; e.klo = klo; e.khi = khi; e.vlo = vlo; e.vhi = vhi;
        e.idx = idx; e.olo = olo; e.ohi = ohi; e.lat = lat;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (int'(bus.rom_addr) > rom_max) rom_max = int'(bus.rom_addr);
        if (bus.busy && !prev_busy) t_start = cyc;
        prev_busy = bus.busy;
        if (bus.done != 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=%b expected no done", bus.done);
            end else begin
                e = sb.pop_front();
                chk("done_vec", longint'(bus.done), longint'(1 << e.id));
                chk("rsp_id",   longint'(bus.rsp_id), longint'(e.id));
                chk("key_lo",   longint'(bus.key_lo), e.klo);
                chk("key_hi",   longint'(bus.key_hi), e.khi);
                chk("val_lo",   longint'(bus.val_lo), e.vlo);
                chk("val_hi",   longint'(bus.val_hi), e.vhi);
                chk("idx_lo",   longint'(bus.idx_lo), longint'(e.idx));
                chk("oor_lo",   longint'(bus.oor_lo), longint'(e.olo));
                chk("oor_hi",   longint'(bus.oor_hi), longint'(e.ohi));
                chk("busy_at_done", longint'(bus.busy), 0);
                chk("latency",  longint'(cyc - t_start + 1), longint'(e.lat));
            end
        end
    end

    task automatic wait_dones(input int n);
        int seen = 0;
        for (int k = 0; k < 300 && seen < n; k++) begin
            @(negedge clk);
            if (bus.done != 2'b00) seen++;
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d done pulses expected %0d", seen, n);
        end
    endtask

    task automatic run_one(input int id, input longint q);
        @(negedge clk);
        if (id == 0) bus.query0 = KW'(q);
        else         bus.query1 = KW'(q);
        bus.req[id] = 1'b1;
        wait_dones(1);
        bus.req[id] = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},     longint'(bus.busy), 0);
        chk({tag, "_done"},     longint'(bus.done), 0);
        chk({tag, "_rom_addr"}, longint'(bus.rom_addr), 0);
        chk({tag, "_key_lo"},   longint'(bus.key_lo), 0);
        chk({tag, "_val_hi"},   longint'(bus.val_hi), 0);
        chk({tag, "_idx_lo"},   longint'(bus.idx_lo), 0);
        chk({tag, "_oor"},      longint'({bus.oor_lo, bus.oor_hi, bus.rsp_id}), 0);
    endtask

    initial begin
        bus.req    = 2'b00;
        bus.query0 = '0;
        bus.query1 = '0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset_n = 1'b1;

        // Single requests from requester 0: interior, below range, above range.
        push(0, 20, 30, 1001, 1002, 1, 0, 0, 4);
        run_one(0, 25);
        push(0, 10, 20, 1000, 1001, 0, 1, 0, 3);
        run_one(0, 5);
        push(0, 70, 80, 1006, 1007, 6, 0, 1, 9);
        run_one(0, 95);

        // Requester 1: exact interior match, exact match on the last key.
        push(1, 20, 30, 1001, 1002, 1, 0, 0, 4);
        run_one(1, 20);
        push(1, 70, 80, 1006, 1007, 6, 0, 1, 9);
        run_one(1, 80);

        // Both held: last winner was 1, so grants go 0,1,0,1.
        push(0, 20, 30, 1001, 1002, 1, 0, 0, 4);
        push(1, 50, 60, 1004, 1005, 4, 0, 0, 7);
        push(0, 20, 30, 1001, 1002, 1, 0, 0, 4);
        push(1, 50, 60, 1004, 1005, 4, 0, 0, 7);
        @(negedge clk);
        bus.query0 = KW'(25);
        bus.query1 = KW'(55);
        bus.req    = 2'b11;
        wait_dones(4);
        bus.req = 2'b00;

        // Reset in the middle of a scan: no done for the aborted request.
        @(negedge clk);
        bus.query0 = KW'(75);
        bus.req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid_scan", longint'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push(0, 30, 40, 1002, 1003, 2, 0, 0, 5);
        run_one(0, 35);

        // Query changed after grant must not affect the result.
        push(0, 40, 50, 1003, 1004, 3, 0, 0, 6);
        @(negedge clk);
        bus.query0 = KW'(45);
        bus.req[0] = 1'b1;
        @(negedge clk);
        bus.query0 = KW'(5);
        wait_dones(1);
        bus.req[0] = 1'b0;

        repeat (5) @(negedge clk);
        chk("sb_empty", longint'(sb.size()), 0);
        chk("rom_addr_max", longint'(rom_max), longint'(DEPTH - 1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
